// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencing, one-deep memory pipeline,
// output register with a single skid slot, and a delivered-instruction count.
module fetch_unit #(
  parameter int INST_ADDR_WIDTH = 32,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [INST_ADDR_WIDTH-1:0] flush_pc,
  output logic                       imem_req,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]                imem_rdata,
  output logic [31:0]                instruction_code,
  output logic [INST_ADDR_WIDTH-1:0] pc_out,
  output logic [INST_ADDR_WIDTH-1:0] pc_plus_4_out,
  output logic                       new_valid_out,
  output logic [31:0]                delivered_count
);

  localparam logic [INST_ADDR_WIDTH-1:0] PC_STEP =
    INST_ADDR_WIDTH'(4);

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  typedef struct packed {
    logic [31:0]                insn;
    logic [INST_ADDR_WIDTH-1:0] pc;
  } slot_t;

  state_t                     state;
  logic [INST_ADDR_WIDTH-1:0] pc_reg;
  logic                       req_q;
  logic [INST_ADDR_WIDTH-1:0] req_pc_q;
  slot_t                      out_q;
  logic                       out_v;
  slot_t                      skid_q;
  logic                       skid_v;
  logic [31:0]                count_q;

  slot_t resp;
  logic  load;
  logic  xfer;
  logic  req;

  always_comb begin
    resp      = '0;
    resp.insn = imem_rdata;
    resp.pc   = req_pc_q;
  end

  // Output register is free to take new data when empty or draining.
  assign load = ~out_v | ~stall;
  assign xfer = out_v & ~stall;

  // Never let out + skid + in-flight exceed two entries.
  assign req = (state == RUN)
             & ~flush
             & ~skid_v
             & ~(stall & out_v & req_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      unique case (state)
        BOOT:    state <= RUN;
        RUN:     state <= RUN;
        default: state <= BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg   <= RESET_PC;
      req_q    <= 1'b0;
      req_pc_q <= '0;
    end else if (flush) begin
      pc_reg <= flush_pc;
      req_q  <= 1'b0;
    end else begin
      req_q <= req;
      if (req) begin
        pc_reg   <= pc_reg + PC_STEP;
        req_pc_q <= pc_reg;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      out_v  <= 1'b0;
      skid_q <= '0;
      skid_v <= 1'b0;
    end else if (flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (load) begin
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= req_q;
        if (req_q) begin
          skid_q <= resp;
        end
      end else begin
        out_v <= req_q;
        if (req_q) begin
          out_q <= resp;
        end
      end
    end else if (req_q) begin
      skid_q <= resp;
      skid_v <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (xfer) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign imem_req         = req;
  assign imem_addr        = pc_reg;
  assign instruction_code = out_q.insn;
  assign pc_out           = out_q.pc;
  assign pc_plus_4_out    = out_q.pc + PC_STEP;
  assign new_valid_out    = out_v;
  assign delivered_count  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetches are queued on each
// request and retired on each downstream transfer.
module tb_fetch_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [W-1:0]  flush_pc = '0;
  logic          imem_req;
  logic [W-1:0]  imem_addr;
  logic [31:0]   imem_rdata = 32'h0;
  logic [31:0]   instruction_code;
  logic [W-1:0]  pc_out;
  logic [W-1:0]  pc_plus_4_out;
  logic          new_valid_out;
  logic [31:0]   delivered_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_pc = 32'h0;
  int unsigned mcount = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_insn = 32'h0;
  logic [31:0] hold_pc = 32'h0;

  fetch_unit #(
    .INST_ADDR_WIDTH(W),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .flush(flush),
    .flush_pc(flush_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .instruction_code(instruction_code),
    .pc_out(pc_out),
    .pc_plus_4_out(pc_plus_4_out),
    .new_valid_out(new_valid_out),
    .delivered_count(delivered_count)
  );

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  always #5 clk = ~clk;

  always @(posedge clk)
    imem_rdata <= imem_req ? memfn(imem_addr) : 32'hBAD0BAD0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      exp_pc    = 32'h0;
      mcount    = 0;
      hold_prev = 1'b0;
    end else begin
      n_cmp++;
      if (delivered_count !== mcount) begin
        n_bad++;
        $display("FAIL count: got %0d want %0d", delivered_count, mcount);
      end
      if (hold_prev) begin
        n_cmp++;
        if (new_valid_out !== 1'b1 || instruction_code !== hold_insn ||
            pc_out !== hold_pc) begin
          n_bad++;
          $display("FAIL hold: got v=%b pc=%h insn=%h want v=1 pc=%h insn=%h",
                   new_valid_out, pc_out, instruction_code, hold_pc, hold_insn);
        end
      end
      if (new_valid_out && !stall) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL extra_out: got pc=%h want no output", pc_out);
        end else begin
          e = sb.pop_front();
          if (pc_out !== e.pc || instruction_code !== e.insn ||
              pc_plus_4_out !== e.pc + 32'd4) begin
            n_bad++;
            $display("FAIL out: got pc=%h insn=%h p4=%h want pc=%h insn=%h p4=%h",
                     pc_out, instruction_code, pc_plus_4_out,
                     e.pc, e.insn, e.pc + 32'd4);
          end
        end
        mcount++;
      end
      if (imem_req) begin
        n_cmp++;
        if (imem_addr !== exp_pc) begin
          n_bad++;
          $display("FAIL req_addr: got %h want %h", imem_addr, exp_pc);
        end
        sb.push_back('{exp_pc, memfn(exp_pc)});
        exp_pc = exp_pc + 32'd4;
      end
      hold_prev = new_valid_out && stall && !flush;
      hold_insn = instruction_code;
      hold_pc   = pc_out;
      if (flush) begin
        sb.delete();
        exp_pc = flush_pc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b0 || new_valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_ctl: got req=%b v=%b want 0 0", imem_req, new_valid_out);
    end
    n_cmp++;
    if (instruction_code !== 32'h0 || pc_out !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_out: got insn=%h pc=%h want 0 0", instruction_code, pc_out);
    end
    n_cmp++;
    if (delivered_count !== 32'h0 || imem_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_cnt: got cnt=%h addr=%h want 0 0", delivered_count, imem_addr);
    end
  endtask

  task automatic test_reset_release();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      n_cmp++;
      if (imem_req !== (c >= 1) ||
          (c >= 1 && imem_addr !== 32'(4 * (c - 1)))) begin
        n_bad++;
        $display("FAIL boot_req c%0d: got req=%b addr=%h want req=%b addr=%h",
                 c, imem_req, imem_addr, c >= 1, 32'(4 * (c - 1)));
      end
      n_cmp++;
      if (new_valid_out !== (c >= 3) ||
          (c >= 3 && (pc_out !== 32'(4 * (c - 3)) ||
                      pc_plus_4_out !== 32'(4 * (c - 2))))) begin
        n_bad++;
        $display("FAIL boot_out c%0d: got v=%b pc=%h p4=%h want v=%b pc=%h p4=%h",
                 c, new_valid_out, pc_out, pc_plus_4_out, c >= 3,
                 32'(4 * (c - 3)), 32'(4 * (c - 2)));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    tick();
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_req k%0d: got %b want 0", k, imem_req);
      end
      if (k == 0) held = pc_out;
      if (k < 4) tick();
    end
    tick();
    stall = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (new_valid_out !== 1'b1 || pc_out !== held) begin
      n_bad++;
      $display("FAIL stall_rel0: got v=%b pc=%h want v=1 pc=%h",
               new_valid_out, pc_out, held);
    end
    @(negedge clk);
    n_cmp++;
    if (new_valid_out !== 1'b1 || pc_out !== held + 32'd4) begin
      n_bad++;
      $display("FAIL stall_rel1: got v=%b pc=%h want v=1 pc=%h",
               new_valid_out, pc_out, held + 32'd4);
    end
    repeat (6) tick();
  endtask

  task automatic test_flush_skid();
    repeat (4) tick();
    stall = 1'b1;
    tick();
    flush    = 1'b1;
    flush_pc = 32'h100;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL fl_req: got %b want 0", imem_req);
    end
    tick();
    flush = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || new_valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL fl_redir: got req=%b addr=%h v=%b want 1 00000100 0",
               imem_req, imem_addr, new_valid_out);
    end
    @(negedge clk);
    n_cmp++;
    if (new_valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL fl_gap: got v=%b want 0", new_valid_out);
    end
    @(negedge clk);
    n_cmp++;
    if (new_valid_out !== 1'b1 || pc_out !== 32'h100 ||
        instruction_code !== memfn(32'h100)) begin
      n_bad++;
      $display("FAIL fl_first: got v=%b pc=%h insn=%h want 1 00000100 %h",
               new_valid_out, pc_out, instruction_code, memfn(32'h100));
    end
    repeat (4) tick();
  endtask

  task automatic test_flush_stall();
    repeat (3) tick();
    stall    = 1'b1;
    flush    = 1'b1;
    flush_pc = 32'h200;
    tick();
    flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || new_valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL fs_redir: got req=%b addr=%h v=%b want 1 00000200 0",
               imem_req, imem_addr, new_valid_out);
    end
    tick();
    stall = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    n_cmp++;
    if (new_valid_out !== 1'b1 || pc_out !== 32'h200) begin
      n_bad++;
      $display("FAIL fs_first: got v=%b pc=%h want 1 00000200", new_valid_out, pc_out);
    end
    repeat (3) tick();
  endtask

  task automatic test_wrap();
    logic prev_fc = 1'b0;
    logic seen_req = 1'b0;
    logic seen_out = 1'b0;
    stall    = 1'b1;
    flush    = 1'b1;
    flush_pc = 32'hFFFF_FFF8;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (imem_req && prev_fc) begin
        seen_req = 1'b1;
        n_cmp++;
        if (imem_addr !== 32'h0) begin
          n_bad++;
          $display("FAIL wrap_req: got %h want 00000000", imem_addr);
        end
      end
      if (imem_req) prev_fc = (imem_addr == 32'hFFFF_FFFC);
      if (new_valid_out && pc_out == 32'hFFFF_FFFC && !seen_out) begin
        seen_out = 1'b1;
        n_cmp++;
        if (pc_plus_4_out !== 32'h0) begin
          n_bad++;
          $display("FAIL wrap_p4: got %h want 00000000", pc_plus_4_out);
        end
      end
      tick();
    end
    n_cmp++;
    if (!seen_req || !seen_out) begin
      n_bad++;
      $display("FAIL wrap_timeout: got req_seen=%b out_seen=%b want 1 1",
               seen_req, seen_out);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned start = mcount;
    for (int c = 0; c < 300; c++) begin
      stall = ($urandom_range(0, 9) < 3);
      flush = ($urandom_range(0, 19) == 0);
      if (flush) begin
        stall    = 1'b1;
        flush_pc = {$urandom(), 2'b00};
      end
      tick();
    end
    stall = 1'b0;
    flush = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    n_cmp++;
    if (mcount - start < 100) begin
      n_bad++;
      $display("FAIL b2b_rate: got %0d transfers want >= 100", mcount - start);
    end
    n_cmp++;
    if (delivered_count !== mcount) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d want %0d", delivered_count, mcount);
    end
  endtask

  task automatic test_reset_mid();
    repeat (4) tick();
    stall = 1'b1;
    repeat (2) tick();
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (new_valid_out !== 1'b0 || delivered_count !== 32'h0 ||
        pc_out !== 32'h0 || imem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_rst: got v=%b cnt=%h pc=%h req=%b want 0 0 0 0",
               new_valid_out, delivered_count, pc_out, imem_req);
    end
    stall = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (imem_req !== (c >= 1) ||
          (c >= 1 && imem_addr !== 32'(4 * (c - 1))) ||
          new_valid_out !== (c >= 3) ||
          (c >= 3 && pc_out !== 32'h0)) begin
        n_bad++;
        $display("FAIL mid_restart c%0d: got req=%b addr=%h v=%b pc=%h",
                 c, imem_req, imem_addr, new_valid_out, pc_out);
      end
    end
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_reset_release();
    test_stall();
    test_flush_skid();
    test_flush_stall();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter INST_ADDR_WIDTH, default 32, instruction address width.
REQ-002 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port stall  input  1  downstream not accepting this cycle.
REQ-006 SHALL have port flush  input  1  redirect request, valid this cycle.
REQ-007 SHALL have port flush_pc  input  INST_ADDR_WIDTH  redirect target.
REQ-008 SHALL have port imem_req  output  1  instruction memory read request.
REQ-009 SHALL have port imem_addr  output  INST_ADDR_WIDTH  read address (equals pc_reg).
REQ-010 SHALL have port imem_rdata  input  32  read data, valid the cycle after an accepted request.
REQ-011 SHALL have port instruction_code  output  32  instruction presented downstream.
REQ-012 SHALL have port pc_out  output  INST_ADDR_WIDTH  address of instruction_code.
REQ-013 SHALL have port pc_plus_4_out  output  INST_ADDR_WIDTH  pc_out+4.
REQ-014 SHALL have port new_valid_out  output  1  instruction_code/pc_out valid.
REQ-015 SHALL have port delivered_count  output  32  instructions transferred downstream.

Function
REQ-016 SHALL implement FSM BOOT->RUN: BOOT for exactly one cycle after reset release with imem_req=0, then RUN permanently.
REQ-017 SHALL assert imem_req iff state=RUN, flush=0, skid entry empty, and NOT (stall=1 AND out valid AND a request is in flight).
REQ-018 SHALL, on each cycle with imem_req=1, advance pc_reg to pc_reg+4 modulo 2^INST_ADDR_WIDTH (0xFFFFFFFC wraps to 0x0); otherwise hold pc_reg.
REQ-019 SHALL record an in-flight flag (req_q) and its address for one cycle after each request; the response is imem_rdata in that next cycle.
REQ-020 SHALL hold presented data in an output register plus one skid entry; total buffered+in-flight never exceeds 2.
REQ-021 SHALL define transfer as new_valid_out=1 AND stall=0 in the same cycle; delivered_count +1 per transfer, wrapping at 2^32.
REQ-022 SHALL, when output is empty or transferring: load output from skid if skid valid (skid then takes the response, else empties), else load output with the response (new_valid_out=req_q).
REQ-023 SHALL, when output holds under stall: keep output unchanged and write any arriving response into the skid entry.
REQ-024 SHALL keep instruction_code/pc_out stable while new_valid_out=1 and stall=1.
REQ-025 SHALL, on flush=1 (priority over stall and responses): set pc_reg=flush_pc, clear output valid, skid valid and req_q at the edge; the arriving response that cycle is discarded; no transfer is counted for the flush cycle's response.
REQ-026 SHALL issue the first post-flush request from flush_pc the cycle after flush; new_valid_out for it rises two cycles after that request.
REQ-027 SHALL produce pc_plus_4_out = pc_out+4 modulo 2^INST_ADDR_WIDTH.
REQ-028 SHALL give a latency of 2 cycles from request (imem_req=1) to new_valid_out=1 with stall=0, and sustain 1 instruction/cycle.

Reset
REQ-029 SHALL on reset: state=BOOT, pc_reg=RESET_PC, req_q=0, skid invalid, new_valid_out=0, instruction_code=0, pc_out=0, delivered_count=0.
REQ-030 SHALL on reset asserted mid-operation drop all buffered and in-flight instructions immediately (asynchronous) without counting them.

Verification
REQ-031 SHALL cover: reset release, RESET_PC=0, no stall -> imem_addr 0,4,8 from cycle 2; new_valid_out high from cycle 4 with pc_out 0,4,8; pc_plus_4_out 4,8,12.
REQ-032 SHALL cover: stall held 5 cycles during streaming -> output frozen, exactly one response into skid, imem_req low; on release no instruction lost or duplicated, delivered_count matches.
REQ-033 SHALL cover: flush with flush_pc=0x100 while skid full and request in flight -> all discarded, next imem_addr=0x100, next valid pc_out=0x100.
REQ-034 SHALL cover: flush and stall same cycle -> flush wins, redirect to flush_pc.
REQ-035 SHALL cover: pc_reg at 0xFFFFFFFC -> next request address 0x00000000; pc_plus_4_out of 0xFFFFFFFC is 0.
REQ-036 SHALL cover: reset asserted with output and skid valid -> new_valid_out=0, delivered_count=0 immediately, restart from RESET_PC.
